execute_stage: RTL

Execute (EX) stage of the 16-bit MIPS-style pipeline, sitting between decode and data memory. It computes the ALU result from decode operands and registers the memory-stage inputs: address/result, store data, read/write, enable and result-mux select. Multiply runs iteratively over several cycles, and the stage stalls decode while it runs.

---
 rtl/exec_pkg.sv | 27 ++
 rtl/execute_stage_mul_iter.sv | 69 ++++++
 rtl/execute_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared EX-stage definitions: datapath widths, ALU opcodes and multiplier FSM states.
// Imported by execute_stage and mul_iter.
package exec_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_SLT   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/execute_stage_mul_iter.sv
// Iterative 16x16 shift-add multiplier (low 16 bits), compiled only with EXEC_MUL_EN.
// start in IDLE -> 16 BUSY steps -> DONE for one cycle -> IDLE; sync active-low reset aborts.
`ifdef EXEC_MUL_EN
module mul_iter
  import exec_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  mul_state_t        r_state;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic              r_done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state  <= ST_BUSY;
            r_cnt    <= '0;
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
          end
        end
        ST_BUSY: begin
          // Multiplicand bits shifted past bit 15 only affect the discarded high half.
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign done    = r_done;
  assign product = r_acc;

endmodule
`endif

// File: rtl/execute_stage.sv
// EX stage: combinational ALU plus the EX/MEM pipeline register; latency 1, one op per cycle.
// With EXEC_MUL_EN, MUL runs on mul_iter and holds decode via stall_ex for 17 cycles.
module execute_stage
  import exec_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_id,
  input  logic [3:0]        alu_op_id,
  input  logic [DATA_W-1:0] a_id,
  input  logic [DATA_W-1:0] b_id,
  input  logic [DATA_W-1:0] imm_id,
  input  logic              use_imm_id,
  input  logic              mem_en_id,
  input  logic              mem_rw_id,
  input  logic              mem_mux_sel_id,
  input  logic              wb_en_id,
  input  logic [REG_W-1:0]  rd_id,
  output logic              stall_ex,
  output logic [DATA_W-1:0] ans_ex,
  output logic [DATA_W-1:0] DM_data,
  output logic              mem_en_ex,
  output logic              mem_rw_ex,
  output logic              mem_mux_sel_ex,
  output logic              wb_en_ex,
  output logic [REG_W-1:0]  rd_ex,
  output logic              zero_ex
);

  logic [DATA_W-1:0] w_b_op;
  logic [3:0]        w_shamt;
  logic [DATA_W-1:0] w_alu;
  logic              w_accept;

  logic [DATA_W-1:0] r_ans;
  logic [DATA_W-1:0] r_dm;
  logic              r_mem_en;
  logic              r_mem_rw;
  logic              r_mem_mux_sel;
  logic              r_wb_en;
  logic [REG_W-1:0]  r_rd;
  logic              r_zero;

  assign w_b_op  = use_imm_id ? imm_id : b_id;
  assign w_shamt = w_b_op[3:0];

`ifdef EXEC_MUL_EN
  logic              w_mul_start;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_mul_product;

  // mul_iter ignores start outside IDLE, so a held MUL does not restart while BUSY/DONE.
  assign w_mul_start = valid_id && (alu_op_id == OP_MUL);
  assign stall_ex    = w_mul_start && !w_mul_done;

  mul_iter u_mul_iter (
    .clk     (clk),
    .reset   (reset),
    .start   (w_mul_start),
    .a       (a_id),
    .b       (w_b_op),
    .done    (w_mul_done),
    .product (w_mul_product)
  );
`else
  assign stall_ex = 1'b0;
`endif

  always_comb begin
    w_alu = '0;
    case (alu_op_id)
      OP_ADD:   w_alu = a_id + w_b_op;
      OP_SUB:   w_alu = a_id - w_b_op;
      OP_AND:   w_alu = a_id & w_b_op;
      OP_OR:    w_alu = a_id | w_b_op;
      OP_XOR:   w_alu = a_id ^ w_b_op;
      OP_NOR:   w_alu = ~(a_id | w_b_op);
      OP_SLL:   w_alu = a_id << w_shamt;
      OP_SRL:   w_alu = a_id >> w_shamt;
      OP_SRA:   w_alu = $unsigned($signed(a_id) >>> w_shamt);
      OP_SLT:   w_alu = {{(DATA_W-1){1'b0}}, ($signed(a_id) < $signed(w_b_op))};
      OP_PASSB: w_alu = w_b_op;
`ifdef EXEC_MUL_EN
      OP_MUL:   w_alu = w_mul_product;
`endif
      default:  w_alu = '0;
    endcase
  end

  assign w_accept = valid_id && !stall_ex;

  // Bubbles clear only the side-effecting controls; data fields keep their last value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ans         <= '0;
      r_dm          <= '0;
      r_mem_en      <= 1'b0;
      r_mem_rw      <= 1'b0;
      r_mem_mux_sel <= 1'b0;
      r_wb_en       <= 1'b0;
      r_rd          <= '0;
      r_zero        <= 1'b0;
    end else if (w_accept) begin
      r_ans         <= w_alu;
      r_dm          <= b_id;
      r_mem_en      <= mem_en_id;
      r_mem_rw      <= mem_rw_id;
      r_mem_mux_sel <= mem_mux_sel_id;
      r_wb_en       <= wb_en_id;
      r_rd          <= rd_id;
      r_zero        <= (w_alu == '0);
    end else begin
      r_mem_en      <= 1'b0;
      r_mem_rw      <= 1'b0;
      r_mem_mux_sel <= 1'b0;
      r_wb_en       <= 1'b0;
    end
  end

  assign ans_ex         = r_ans;
  assign DM_data        = r_dm;
  assign mem_en_ex      = r_mem_en;
  assign mem_rw_ex      = r_mem_rw;
  assign mem_mux_sel_ex = r_mem_mux_sel;
  assign wb_en_ex       = r_wb_en;
  assign rd_ex          = r_rd;
  assign zero_ex        = r_zero;

endmodule
